// File: rtl/sodor5_instr_sched.sv
// Random RV32I OP-IMM / load instruction source for the Sodor 5-stage imem response port.
// Runs a fixed instruction budget with load-use bubbles, drains with NOPs, then reports done.
module sodor5_instr_sched #(
   parameter logic [31:0] SEED       = 32'h0000009D,
   parameter int unsigned NUM_INSTR  = 64,
   parameter int unsigned DRAIN_NOPS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [11:0] load_imm_mask,
   input  logic        imem_resp_ready,
   output logic        imem_resp_valid,
   output logic [31:0] imem_resp_bits_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] issued_count
);

   // state   | meaning
   // S_IDLE  | NOP held, waiting for start
   // S_RUN   | issuing counted instructions and load-use bubbles
   // S_DRAIN | NOPs until the pipeline has flushed
   // S_DONE  | NOP held, done high, start relaunches without reseed
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [31:0] NOP      = 32'h00000013;
   localparam logic [31:0] TAPS     = 32'h80200003;
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [15:0] NUM_L    = 16'(NUM_INSTR);
   localparam logic [7:0]  DRAIN_L  = 8'(DRAIN_NOPS);
   localparam logic [6:0]  OP_LOAD  = 7'b0000011;

   state_t      state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [31:0] data_q, data_d;
   logic        bubble_q, bubble_d;
   logic [4:0]  last_rd_q, last_rd_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  drain_q, drain_d;
   logic [31:0] cand;
   logic        haz;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return {1'b0, l[31:1]} ^ (l[0] ? TAPS : 32'h0);
   endfunction

   function automatic logic [31:0] gen_word(input logic [31:0] l, input logic [1:0] md,
                                            input logic [11:0] msk);
      logic [11:0] imm;
      logic        use_op;
      imm = l[11:0];
      if (l[19:17] == 3'd5)      imm = imm & 12'h41F;
      else if (l[19:17] == 3'd1) imm = imm & 12'h01F;
      use_op = (md == 2'b00) ? l[25] : (md == 2'b01);
      if (md == 2'b11)
         return NOP;
      else if (use_op)
         return {imm, l[16:12], l[19:17], l[24:20], 7'b0010011};
      else
         return {({l[31:27], l[6:0]} & msk), l[16:12], {l[26], 2'b00}, l[24:20], OP_LOAD};
   endfunction

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      data_d    = data_q;
      bubble_d  = bubble_q;
      last_rd_d = last_rd_q;
      cnt_d     = cnt_q;
      drain_d   = drain_q;
      cand      = NOP;
      haz       = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (imem_resp_ready) last_rd_d = '0;
            if (start) begin
               state_d  = S_RUN;
               cnt_d    = '0;
               drain_d  = '0;
               cand     = gen_word(lfsr_q, mode, load_imm_mask);
               haz      = (last_rd_d != 5'd0) && (cand[19:15] == last_rd_d);
               data_d   = haz ? NOP : cand;
               bubble_d = haz;
            end
         end
         S_RUN: begin
            if (imem_resp_ready) begin
               if (bubble_q) begin
                  // candidate was held back by the bubble; L did not step
                  last_rd_d = '0;
                  data_d    = gen_word(lfsr_q, mode, load_imm_mask);
                  bubble_d  = 1'b0;
               end else begin
                  cnt_d     = cnt_q + 16'd1;
                  lfsr_d    = lfsr_step(lfsr_q);
                  last_rd_d = (data_q[6:0] == OP_LOAD) ? data_q[11:7] : 5'd0;
                  if (cnt_d == NUM_L) begin
                     state_d  = S_DRAIN;
                     data_d   = NOP;
                     bubble_d = 1'b0;
                  end else begin
                     cand     = gen_word(lfsr_d, mode, load_imm_mask);
                     haz      = (last_rd_d != 5'd0) && (cand[19:15] == last_rd_d);
                     data_d   = haz ? NOP : cand;
                     bubble_d = haz;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (imem_resp_ready) begin
               last_rd_d = '0;
               drain_d   = drain_q + 8'd1;
               if (drain_d == DRAIN_L) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         lfsr_q    <= SEED_EFF;
         data_q    <= NOP;
         bubble_q  <= 1'b0;
         last_rd_q <= '0;
         cnt_q     <= '0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         data_q    <= data_d;
         bubble_q  <= bubble_d;
         last_rd_q <= last_rd_d;
         cnt_q     <= cnt_d;
         drain_q   <= drain_d;
      end
   end

   assign imem_resp_valid     = 1'b1;
   assign imem_resp_bits_data = data_q;
   assign busy                = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done                = (state_q == S_DONE);
   assign issued_count        = cnt_q;

endmodule

// File: tb/tb_sodor5_instr_sched.sv
// Directed bench for sodor5_instr_sched: hand-computed streams on three seeds plus a
// load-mode scoreboard for bubble placement and count.
module tb_sodor5_instr_sched;

   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_start, a_rdy;
   logic [1:0]  a_mode;
   logic [11:0] a_mask;
   logic        a_val, a_busy, a_done;
   logic [31:0] a_data;
   logic [15:0] a_cnt;

   logic        b_rst, b_start, b_rdy;
   logic [1:0]  b_mode;
   logic [11:0] b_mask;
   logic        b_val, b_busy, b_done;
   logic [31:0] b_data;
   logic [15:0] b_cnt;

   logic        c_val, c_busy, c_done;
   logic [31:0] c_data;
   logic [15:0] c_cnt;

   sodor5_instr_sched #(.SEED(32'h00020000), .NUM_INSTR(4), .DRAIN_NOPS(2)) u_a (
      .clk(clk), .reset(a_rst), .start(a_start), .mode(a_mode), .load_imm_mask(a_mask),
      .imem_resp_ready(a_rdy), .imem_resp_valid(a_val), .imem_resp_bits_data(a_data),
      .busy(a_busy), .done(a_done), .issued_count(a_cnt));

   sodor5_instr_sched #(.SEED(32'h0), .NUM_INSTR(32), .DRAIN_NOPS(8)) u_b (
      .clk(clk), .reset(b_rst), .start(b_start), .mode(b_mode), .load_imm_mask(b_mask),
      .imem_resp_ready(b_rdy), .imem_resp_valid(b_val), .imem_resp_bits_data(b_data),
      .busy(b_busy), .done(b_done), .issued_count(b_cnt));

   sodor5_instr_sched #(.SEED(32'h00102000), .NUM_INSTR(32), .DRAIN_NOPS(8)) u_c (
      .clk(clk), .reset(b_rst), .start(b_start), .mode(b_mode), .load_imm_mask(b_mask),
      .imem_resp_ready(b_rdy), .imem_resp_valid(c_val), .imem_resp_bits_data(c_data),
      .busy(c_busy), .done(c_done), .issued_count(c_cnt));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic [31:0] d, input logic [15:0] cnt,
                          input logic bsy, input logic dn);
      check_eq({tag, "_valid"}, a_val, 1'b1);
      check_eq({tag, "_data"}, a_data, d);
      check_eq({tag, "_cnt"}, a_cnt, cnt);
      check_eq({tag, "_busy"}, a_busy, bsy);
      check_eq({tag, "_done"}, a_done, dn);
   endtask

   function automatic logic [31:0] m_step(input logic [31:0] l);
      return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
   endfunction

   // load-mode word straight from the field definitions
   function automatic logic [31:0] m_load(input logic [31:0] l, input logic [11:0] msk);
      logic [11:0] imm;
      imm = {l[31:27], l[6:0]} & msk;
      return {imm, l[16:12], l[26], 2'b00, l[24:20], 7'b0000011};
   endfunction

   logic [31:0] run1 [4];
   logic [31:0] run2 [4];
   logic [31:0] c_exp [3];
   logic [15:0] c_cnt_exp [3];
   logic [31:0] exp_w [32];
   logic        hz [32];

   initial begin
      logic [31:0] l, w, prev;
      int k, exp_bub, obs_bub;
      logic bub_done;

      run1 = '{32'h00001013, 32'h00080013, 32'h00040013, 32'h00020013};
      run2 = '{32'h00010013, 32'h00008013, 32'h80000013, 32'h40000013};
      c_exp = '{32'h00010083, NOP, 32'h00008003};
      c_cnt_exp = '{16'd0, 16'd1, 16'd1};

      a_rst = 1'b1; a_start = 1'b0; a_rdy = 1'b1; a_mode = 2'b01; a_mask = 12'hFFF;
      b_rst = 1'b1; b_start = 1'b0; b_rdy = 1'b1; b_mode = 2'b10; b_mask = 12'hFFF;

      // reset and idle hold
      for (int i = 0; i < 3; i++) begin
         tick();
         check_a("rst", NOP, 16'd0, 1'b0, 1'b0);
      end
      a_rst = 1'b0; b_rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_a("idle", NOP, 16'd0, 1'b0, 1'b0);
      end

      // first run, budget 4, drain 2
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_a("run1", run1[i], 16'(i), 1'b1, 1'b0);
         tick();
      end
      check_a("drain0", NOP, 16'd4, 1'b1, 1'b0);
      tick();
      check_a("drain1", NOP, 16'd4, 1'b1, 1'b0);
      tick();
      check_a("done", NOP, 16'd4, 1'b0, 1'b1);
      tick();
      check_a("done_hold", NOP, 16'd4, 1'b0, 1'b1);

      // restart continues the LFSR, with a 4-cycle stall mid-run
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check_a("run2_0", run2[0], 16'd0, 1'b1, 1'b0);
      tick();
      check_a("run2_1", run2[1], 16'd1, 1'b1, 1'b0);
      a_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_a("stall", run2[1], 16'd1, 1'b1, 1'b0);
      end
      a_rdy = 1'b1;
      tick();
      check_a("run2_2", run2[2], 16'd2, 1'b1, 1'b0);
      tick();
      check_a("run2_3", run2[3], 16'd3, 1'b1, 1'b0);

      // reset mid-run returns to IDLE and reseeds
      a_rst = 1'b1;
      tick();
      check_a("rst_mid", NOP, 16'd0, 1'b0, 1'b0);
      a_rst = 1'b0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check_a("reseed", run1[0], 16'd0, 1'b1, 1'b0);

      // load-mode scoreboard for u_b (seed 0 -> 1); u_c has a forced load-use pair
      l = 32'h1;
      exp_bub = 0;
      for (int i = 0; i < 32; i++) begin
         exp_w[i] = m_load(l, 12'hFFF);
         l = m_step(l);
         hz[i] = (i > 0) && (exp_w[i-1][6:0] == 7'b0000011) && (exp_w[i-1][11:7] != 5'd0)
                 && (exp_w[i][19:15] == exp_w[i-1][11:7]);
         if (hz[i]) exp_bub++;
      end
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check_eq("b_first", b_data, 32'h00100003);
      k = 0; bub_done = 1'b0; obs_bub = 0;
      for (int cyc = 0; cyc < 400 && k < 32; cyc++) begin
         w = (hz[k] && !bub_done) ? NOP : exp_w[k];
         check_eq("b_word", b_data, w);
         check_eq("b_cnt", b_cnt, 16'(k));
         check_eq("b_f3", b_data[13:12], 2'b00);
         if (cyc < 3) begin
            check_eq("c_word", c_data, c_exp[cyc]);
            check_eq("c_cnt", c_cnt, c_cnt_exp[cyc]);
         end
         prev = b_data;
         b_rdy = (cyc % 5) != 3;
         tick();
         if (b_rdy) begin
            if (prev == NOP) obs_bub++;
            if (w == NOP) bub_done = 1'b1;
            else begin
               k++;
               bub_done = 1'b0;
            end
         end
      end
      check_eq("b_budget_reached", k, 32);
      check_eq("b_final_cnt", b_cnt, 16'd32);
      check_eq("b_bubbles", obs_bub, exp_bub);
      b_rdy = 1'b1;
      for (int i = 0; i < 20 && !b_done; i++) tick();
      check_eq("b_done", b_done, 1'b1);
      check_eq("b_done_busy", b_busy, 1'b0);

      // OP-IMM restart: opcode and shift-immediate masking
      b_mode = 2'b01;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check_eq("b_restart_cnt", b_cnt, 16'd0);
      check_eq("b_restart_busy", b_busy, 1'b1);
      for (int i = 0; i < 20; i++) begin
         check_eq("b_opimm_opc", b_data[6:0], 7'b0010011);
         if (b_data[14:12] == 3'd1) check_eq("b_slli_imm", b_data[31:25], 7'd0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
